// File: rtl/matrix_fetch_loader_if.sv
// Avalon-MM read port of mem_wrapper plus the shared byte write side of the
// B FIFO and the NUM_ROWS_A A FIFOs.
interface matrix_fetch_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 8,
  parameter int NUM_ROWS_A = 8,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]            address;
  logic                             read;
  logic [DATA_WIDTH*WORD_BYTES-1:0] readdata;
  logic                             readdatavalid;
  logic                             waitrequest;
  logic [DATA_WIDTH-1:0]            fifo_data;
  logic                             wrreq_B;
  logic                             wrfull_B;
  logic [NUM_ROWS_A-1:0]            wrreq_A;
  logic [NUM_ROWS_A-1:0]            wrfull_A;

  modport master (
    output address, read, fifo_data, wrreq_B, wrreq_A,
    input  readdata, readdatavalid, waitrequest, wrfull_B, wrfull_A
  );

  modport slave (
    input  address, read, fifo_data, wrreq_B, wrreq_A,
    output readdata, readdatavalid, waitrequest, wrfull_B, wrfull_A
  );
endinterface

// File: rtl/matrix_fetch_loader.sv
// Fill stage for the systolic MAC array: fetches the B word and the A row words
// one at a time and serializes each into its input FIFO, LSB byte first.
module matrix_fetch_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    WORD_BYTES = 8,
  parameter int                    NUM_ROWS_A = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  matrix_fetch_loader_if.master bus
);
  localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
  localparam int BYTE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int ROW_W  = $clog2(NUM_ROWS_A + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS_A);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ROW_W-1:0]      r_row;
  logic [BYTE_W-1:0]     r_byte;
  logic [WORD_W-1:0]     r_word;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_read;
  logic [ADDR_WIDTH-1:0] r_address;

  logic                  w_row_is_b;
  logic [NUM_ROWS_A-1:0] w_row_sel_a;
  logic                  w_target_full;
  logic                  w_write;
  logic                  w_last_byte;
  logic                  w_last_row;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  // Row 0 targets the B FIFO, row r targets A FIFO r-1; a full target stalls the shift.
  always_comb begin
    w_row_is_b  = (r_row == {ROW_W{1'b0}});
    w_row_sel_a = {NUM_ROWS_A{1'b0}};
    for (int i = 0; i < NUM_ROWS_A; i++) begin
      w_row_sel_a[i] = (r_row == ROW_W'(i + 1));
    end
    w_target_full = w_row_is_b ? bus.wrfull_B : (|(w_row_sel_a & bus.wrfull_A));
    w_write       = (r_state == ST_SHIFT) && !w_target_full;
    w_last_byte   = (r_byte == LAST_BYTE);
    w_last_row    = (r_row == LAST_ROW);
  end

  // Byte lane select out of the latched word.
  always_comb begin
    w_fifo_data = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < WORD_BYTES; i++) begin
      w_fifo_data = w_fifo_data |
        ((r_byte == BYTE_W'(i)) ? r_word[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}});
    end
  end

  // Next-state decode for the fetch/serialize sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_next_state = i_start ? ST_REQ : r_state;
      ST_REQ:           w_next_state = bus.waitrequest ? ST_REQ : ST_WAIT;
      ST_WAIT:          w_next_state = bus.readdatavalid ? ST_SHIFT : ST_WAIT;
      ST_SHIFT: begin
        if (w_write && w_last_byte) begin
          w_next_state = w_last_row ? ST_DONE : ST_REQ;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // State, counters, captured word and the registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_row     <= {ROW_W{1'b0}};
      r_byte    <= {BYTE_W{1'b0}};
      r_word    <= {WORD_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_read    <= 1'b0;
      r_address <= BASE_ADDR;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_row     <= {ROW_W{1'b0}};
            r_byte    <= {BYTE_W{1'b0}};
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_read    <= 1'b1;
            r_address <= BASE_ADDR;
          end
        end
        ST_REQ: begin
          if (!bus.waitrequest) begin
            r_read <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.readdatavalid) begin
            r_word <= bus.readdata;
            r_byte <= {BYTE_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          if (w_write && w_last_byte) begin
            r_byte <= {BYTE_W{1'b0}};
            if (w_last_row) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_row     <= r_row + ROW_W'(1);
              r_read    <= 1'b1;
              r_address <= BASE_ADDR + ADDR_WIDTH'(r_row) + ADDR_WIDTH'(1);
            end
          end else if (w_write) begin
            r_byte <= r_byte + BYTE_W'(1);
          end
        end
        default: begin
          r_read <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign bus.read      = r_read;
  assign bus.address   = r_address;
  assign bus.fifo_data = w_fifo_data;
  assign bus.wrreq_B   = w_write && w_row_is_b;
  assign bus.wrreq_A   = {NUM_ROWS_A{w_write}} & w_row_sel_a;
endmodule
